// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 raster timing generator on the pixel clock.
// Every output is registered from the next-state decode, so flags line up with DrawX/DrawY.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_range_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
    end

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       x_wrap;
    logic       origin_nxt;
    logic       started;

    always_comb begin
        x_wrap     = (DrawX == H_LAST);
        x_nxt      = x_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt      = DrawY;
        if (x_wrap)
            y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        origin_nxt = (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
            started     <= 1'b0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hsync       <= ((x_nxt >= HS_BEG) && (x_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync       <= ((y_nxt >= VS_BEG) && (y_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            line_start  <= (x_nxt == 10'd0);
            frame_start <= origin_nxt;
            // The origin reached straight out of reset opens frame 0; only later ones count.
            started     <= 1'b1;
            if (origin_nxt && started)
                frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunken
// instance so whole frames and the frame_count wrap fit in a short run.
module tb_vga_timing_gen;

    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 2;
    localparam int SHT = SHA + SHF + SHS + SHB;   // 15
    localparam int SVT = SVA + SVF + SVS + SVB;   // 11

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       b;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct { int x; int y; int fc; bit seen; } mst_t;
    typedef struct { bit rst; int n; obs_t o; } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [9:0] x_d, y_d, x_s, y_s;
    logic       b_d, hs_d, vs_d, ls_d, fs_d, b_s, hs_s, vs_s, ls_s, fs_s;
    logic [7:0] fc_d, fc_s;
    obs_t       o_d, o_s;
    assign o_d = {x_d, y_d, b_d, hs_d, vs_d, ls_d, fs_d, fc_d};
    assign o_s = {x_s, y_s, b_s, hs_s, vs_s, ls_s, fs_s, fc_s};

    vga_timing_gen dut (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(x_d), .DrawY(y_d), .blank(b_d),
        .hsync(hs_d), .vsync(vs_d), .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b0)
    ) dut_s (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(x_s), .DrawY(y_s), .blank(b_s),
        .hsync(hs_s), .vsync(vs_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    mst_t md = '{0, 0, 0, 1'b0};
    mst_t ms = '{0, 0, 0, 1'b0};
    obs_t q_d[$];
    obs_t q_s[$];
    vec_t tbl[11];

    function automatic obs_t mk(int x, int y, bit b, bit hs, bit vs, bit ls, bit fs, int fc);
        obs_t o;
        o.x = 10'(x); o.y = 10'(y); o.b = b; o.hs = hs; o.vs = vs;
        o.ls = ls; o.fs = fs; o.fc = 8'(fc);
        return o;
    endfunction

    function automatic mst_t mstep(mst_t s, bit rst_n, int ht, int vt);
        mst_t n = s;
        if (!rst_n) begin
            n.x = ht - 1; n.y = vt - 1; n.fc = 0; n.seen = 1'b0;
        end else begin
            if (s.x == ht - 1) begin
                n.x = 0;
                n.y = (s.y == vt - 1) ? 0 : s.y + 1;
            end else begin
                n.x = s.x + 1;
            end
            if (n.x == 0 && n.y == 0) begin
                if (n.seen) n.fc = (n.fc + 1) % 256;
                n.seen = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic obs_t mobs(mst_t s, bit rst_n, int ha, int hf, int hsw, int va, int vf, int vsw);
        if (!rst_n) return mk(s.x, s.y, 0, 1, 1, 0, 0, 0);
        return mk(s.x, s.y,
                  (s.x < ha) && (s.y < va),
                  !((s.x >= ha + hf) && (s.x < ha + hf + hsw)),
                  !((s.y >= va + vf) && (s.y < va + vf + vsw)),
                  s.x == 0, (s.x == 0) && (s.y == 0), s.fc);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     nm, act.x, act.y, act.b, act.hs, act.vs, act.ls, act.fs, act.fc,
                     exp.x, exp.y, exp.b, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
        end
    endtask

    // One clock: model advances on the edge, DUT outputs are compared on the falling edge.
    task automatic tick();
        obs_t e;
        @(posedge clk);
        cyc++;
        md = mstep(md, reset_n, 800, 525);
        ms = mstep(ms, reset_n, SHT, SVT);
        q_d.push_back(mobs(md, reset_n, 640, 16, 96, 480, 10, 2));
        q_s.push_back(mobs(ms, reset_n, SHA, SHF, SHS, SVA, SVF, SVS));
        @(negedge clk);
        e = q_d.pop_front();
        chk_obs("cont_full", o_d, e);
        e = q_s.pop_front();
        chk_obs("cont_small", o_s, e);
    endtask

    initial begin
        int hlow, bhi, nfs, t_last, vlow, bcnt;
        bit found;
        reset_n = 1'b0;
        //            rst   n     x    y   b  hs vs ls fs fc
        tbl[0]  = '{1'b0,  2, mk(799, 524, 0, 1, 1, 0, 0, 0)};
        tbl[1]  = '{1'b1,  1, mk(  0,   0, 1, 1, 1, 1, 1, 0)};
        tbl[2]  = '{1'b1, 639, mk(639,  0, 1, 1, 1, 0, 0, 0)};
        tbl[3]  = '{1'b1,  1, mk(640,   0, 0, 1, 1, 0, 0, 0)};
        tbl[4]  = '{1'b1, 15, mk(655,   0, 0, 1, 1, 0, 0, 0)};
        tbl[5]  = '{1'b1,  1, mk(656,   0, 0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{1'b1, 95, mk(751,   0, 0, 0, 1, 0, 0, 0)};
        tbl[7]  = '{1'b1,  1, mk(752,   0, 0, 1, 1, 0, 0, 0)};
        tbl[8]  = '{1'b1, 47, mk(799,   0, 0, 1, 1, 0, 0, 0)};
        tbl[9]  = '{1'b1,  1, mk(  0,   1, 1, 1, 1, 1, 0, 0)};
        tbl[10] = '{1'b0,  1, mk(799, 524, 0, 1, 1, 0, 0, 0)};

        for (int i = 0; i < 11; i++) begin
            reset_n = tbl[i].rst;
            repeat (tbl[i].n) tick();
            chk_obs($sformatf("vec%0d", i), o_d, tbl[i].o);
        end

        // One full line from the origin: hsync width and visible span.
        reset_n = 1'b1;
        tick();
        hlow = 0; bhi = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            if (!hs_d) hlow++;
            if (b_d) bhi++;
        end
        chk("hsync_low_clocks", hlow, 96);
        chk("blank_high_clocks", bhi, 640);
        tick();
        chk("line_wrap_x", x_d, 0);
        chk("line_wrap_y", y_d, 1);

        // Small instance: frame period, vsync width, frame_count wrap.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("small_first_fs", fs_s, 1);
        chk("small_first_fc", fc_s, 0);
        t_last = cyc; nfs = 0;
        vlow = vs_s ? 0 : 1;
        bcnt = b_s ? 1 : 0;
        for (int i = 0; i < 260 * SHT * SVT && nfs < 256; i++) begin
            tick();
            if (fs_s) begin
                nfs++;
                chk("fs_period", cyc - t_last, SHT * SVT);
                t_last = cyc;
                if (nfs == 1) begin
                    chk("fc_after_frame1", fc_s, 1);
                    chk("vsync_low_clocks", vlow, SVS * SHT);
                    chk("blank_frame_clocks", bcnt, SHA * SVA);
                end
                if (nfs == 255) chk("fc_255", fc_s, 255);
                if (nfs == 256) chk("fc_wrap", fc_s, 0);
            end else if (nfs == 0) begin
                if (!vs_s) vlow++;
                if (b_s) bcnt++;
            end
        end
        if (nfs < 256) chk("frame_wait_timeout", nfs, 256);

        // Reset in the middle of a frame.
        found = 1'b0;
        for (int i = 0; i < 2 * SHT * SVT && !found; i++) begin
            tick();
            if (x_s == 10'd12 && y_s == 10'd7 && fc_s == 8'd1) found = 1'b1;
        end
        chk("midframe_point_found", found, 1);
        reset_n = 1'b0;
        tick();
        chk_obs("midframe_reset", o_s, mk(SHT - 1, SVT - 1, 0, 1, 1, 0, 0, 0));
        reset_n = 1'b1;
        tick();
        chk_obs("midframe_restart", o_s, mk(0, 0, 1, 1, 1, 1, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running 640x480@60 Hz raster timing generator clocked by the 25 MHz pixel clock.
- Sits directly upstream of the sprite/background renderers. It drives their DrawX, DrawY and blank inputs, and drives the board hsync/vsync pins.
- Also emits frame and line strobes plus a frame counter for game animation and logic updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  synchronous active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (DrawX<H_ACTIVE and DrawY<V_ACTIVE); 0 = blanking
- hsync  out  1  horizontal sync, SYNC_POL when asserted
- vsync  out  1  vertical sync, SYNC_POL when asserted
- line_start  out  1  one-cycle pulse when DrawX==0
- frame_start  out  1  one-cycle pulse when DrawX==0 and DrawY==0
- frame_count  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK = 800
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK = 525
- Counters:
  - DrawX increments every clock. At H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps from V_TOTAL-1 to 0 on the same edge that DrawX wraps.
  - No stall or enable input; the counters never hold except in reset.
- Output alignment:
  - All outputs are registers. Each register loads the decode of the next counter value, so every output is valid for the DrawX/DrawY shown in the same cycle.
  - There is zero skew between coordinates and flags. The downstream renderer adds its own pipeline delay.
- Decodes, as functions of (DrawX, DrawY):
  - hsync asserted iff H_ACTIVE+H_FRONT <= DrawX < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync asserted iff V_ACTIVE+V_FRONT <= DrawY < V_ACTIVE+V_FRONT+V_SYNC, i.e. 490..491. It is a function of line only; it changes on the DrawX wrap edge.
  - blank = (DrawX<640) && (DrawY<480).
  - line_start = (DrawX==0).
  - frame_start = (DrawX==0 && DrawY==0).
- frame_count increments by 1 on the edge where (DrawX,DrawY) goes to (0,0). It does not increment on the first (0,0) after reset. Width is modulo 2^8.
- Reset, sampled at posedge with reset_n==0:
  - DrawX=H_TOTAL-1=799, DrawY=V_TOTAL-1=524
  - blank=0, hsync=vsync=~SYNC_POL, line_start=0, frame_start=0, frame_count=0
- Reset release: the first posedge with reset_n==1 produces DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=0.
- Reset mid-frame: on the next posedge, all state is immediately forced to the reset values above, regardless of position. No partial line completion.
- Counter width: 10 bits covers both 799 and 524. Compares use full-width unsigned arithmetic. Parameter sums must be < 1024; an elaboration-time check flags violations.

Test Plan:
- Reset then release -> first cycle (DrawX,DrawY)=(0,0), blank=1, frame_start=1, line_start=1, hsync=vsync=1, frame_count=0.
- Run one line from (0,0) -> blank falls at DrawX=640. hsync low for exactly 96 clocks, DrawX 656..751. DrawX wraps 799->0 with DrawY 0->1 on the same edge. Line period 800 clocks.
- Run a full frame -> vsync low exactly on lines 490-491 (1600 clocks). blank=0 for all DrawY>=480. frame_start period = 420000 clocks. frame_count=1 at second (0,0).
- Run 256 frames (or force counters near wrap) -> frame_count wraps 255->0 on the 256th frame_start after the first.
- Assert reset_n=0 for one cycle at (DrawX,DrawY)=(700,300) -> next cycle (799,524), blank=0, frame_count=0. The following cycle is (0,0) with frame_start=1.
- Continuous check, every cycle -> blank, hsync and vsync match the decode equations of the same-cycle DrawX/DrawY. line_start and frame_start are single-cycle pulses.
